// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one memory_access port between kernel-fetch (0)
// and pixel-fetch (1); serializes reads, returns data, aborts hung transactions.
module mem_access_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  REQ,
  input  logic [2:0]  CTRL0,
  input  logic [2:0]  CTRL1,
  input  logic [47:0] ADDR0,
  input  logic [47:0] ADDR1,
  output logic [1:0]  GNT,
  output logic [1:0]  DONE,
  output logic [47:0] RDATA,
  output logic        TIMEOUT_ERR,
  output logic        BUSY,
  output logic        MEM_ENABLE,
  output logic [2:0]  MEM_CTRL,
  output logic [47:0] MEM_ADDRESS,
  input  logic [47:0] MEM_READ,
  input  logic        MEM_HANDSHAKE,
  output logic [1:0]  dbg_state
);

  // Handshakes: a requester holds REQ/CTRL/ADDR until GNT, GNT stays high for the
  // whole owned transaction and DONE pulses once with RDATA. Memory side: ENABLE
  // stays high until HANDSHAKE is seen, and GNT is only released once HANDSHAKE
  // has dropped, so a lingering HANDSHAKE can never complete the next transaction.

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [47:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          enable_q, enable_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [47:0]   addr_q, addr_d;
  logic          win;

  // On a tie the requester that did not win last time takes the port.
  always_comb begin
    win = 1'b0;
    case (REQ)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant_q;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    done_d       = 2'b00;
    rdata_d      = rdata_q;
    err_d        = err_q;
    enable_d     = enable_q;
    ctrl_d       = ctrl_q;
    addr_d       = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ != 2'b00) begin
          state_d      = ST_WAIT;
          last_grant_d = win;
          gnt_d        = win ? 2'b10 : 2'b01;
          enable_d     = 1'b1;
          cnt_d        = '0;
          ctrl_d       = win ? CTRL1 : CTRL0;
          addr_d       = win ? ADDR1 : ADDR0;
        end
      end
      ST_WAIT: begin
        // A handshake arriving on the timeout edge still counts as a completion.
        if (MEM_HANDSHAKE) begin
          rdata_d  = MEM_READ;
          done_d   = gnt_q;
          enable_d = 1'b0;
          state_d  = ST_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d  = '0;
          done_d   = gnt_q;
          err_d    = 1'b1;
          enable_d = 1'b0;
          state_d  = ST_RELEASE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (!MEM_HANDSHAKE) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = 2'b00;
        enable_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      enable_q     <= 1'b0;
      ctrl_q       <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      enable_q     <= enable_d;
      ctrl_q       <= ctrl_d;
      addr_q       <= addr_d;
    end
  end

  assign GNT         = gnt_q;
  assign DONE        = done_q;
  assign RDATA       = rdata_q;
  assign TIMEOUT_ERR = err_q;
  assign BUSY        = busy_q;
  assign MEM_ENABLE  = enable_q;
  assign MEM_CTRL    = ctrl_q;
  assign MEM_ADDRESS = addr_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Two-requester arbiter that shares the single `memory_access` port between the kernel-fetch unit (requester 0) and the pixel-fetch unit (requester 1). It serializes their read transactions with round-robin fairness. It drives the memory-side ENABLE/CTRL/ADDRESS, waits for HANDSHAKE, returns the 48-bit read word to the winner, and aborts hung transactions with a timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before abort; legal range 2..255.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  2  per-requester read request; bit i belongs to requester i.
- CTRL0, CTRL1  in  3 each  transaction control. Bit 0: 0 = kernel memory, 1 = picture memory. Bits 2:1: controller mode.
- ADDR0, ADDR1  in  48 each  transaction address; only bits 31:0 are meaningful downstream.
- GNT  out  2  one-hot; high for the whole owned transaction.
- DONE  out  2  one-cycle pulse to the owner when RDATA is valid.
- RDATA  out  48  registered read word; holds its value until the next DONE.
- TIMEOUT_ERR  out  1  sticky; set on abort, cleared only by RESET.
- BUSY  out  1  high whenever the state is not IDLE.
- MEM_ENABLE  out  1  enable to `memory_access`.
- MEM_CTRL  out  3  latched CTRL of the owner.
- MEM_ADDRESS  out  48  latched ADDR of the owner.
- MEM_READ  in  48  read data from `memory_access`.
- MEM_HANDSHAKE  in  1  completion indication from `memory_access`.

## Operation
- Reset values: GNT=0, DONE=0, RDATA=0, TIMEOUT_ERR=0, BUSY=0, MEM_ENABLE=0, MEM_CTRL=0, MEM_ADDRESS=0. State is IDLE. last_grant=1, so requester 0 wins the first tie. Timeout counter is 0.
- States:
  - IDLE → WAIT when REQ≠0.
  - WAIT → RELEASE when MEM_HANDSHAKE=1 or the counter reaches TIMEOUT_CYCLES−1.
  - RELEASE → IDLE when MEM_HANDSHAKE=0.
- Arbitration happens only in IDLE:
  - A single request wins outright.
  - If both request, the winner is the requester ≠ last_grant.
  - last_grant updates to the winner on entry to WAIT.
- On entry to WAIT:
  - Latch the winner's CTRL/ADDR into MEM_CTRL/MEM_ADDRESS.
  - Set GNT[w]=1 and MEM_ENABLE=1.
  - Clear the counter.
- In WAIT:
  - The counter increments each cycle; its width is $clog2(TIMEOUT_CYCLES+1) and it saturates, never wrapping.
  - MEM_CTRL/MEM_ADDRESS stay constant even if requester inputs change.
- Normal completion (MEM_HANDSHAKE=1 sampled in WAIT):
  - RDATA←MEM_READ and DONE[w]=1 for one cycle.
  - MEM_ENABLE←0; go to RELEASE.
- Timeout (counter = TIMEOUT_CYCLES−1 with no handshake):
  - RDATA←0, DONE[w]=1, TIMEOUT_ERR←1.
  - MEM_ENABLE←0; go to RELEASE.
  - If handshake and timeout coincide, the handshake wins: normal completion, no error.
- RELEASE:
  - GNT stays asserted until MEM_HANDSHAKE is sampled low.
  - GNT clears when the state returns to IDLE.
  - This prevents a stale handshake from completing the next transaction.
- Requester rules:
  - Hold REQ/CTRL/ADDR stable until GNT.
  - Drop REQ in the cycle after DONE unless issuing a new request.
  - REQ dropped before a grant is simply never served.
  - REQ dropped during WAIT does not cancel the transaction.
- RESET asserted mid-transaction returns everything to reset values on the next edge. MEM_ENABLE falls immediately, and no DONE is generated.

## Timing
- All outputs are registered.
- REQ sampled high at edge t → GNT and MEM_ENABLE high after edge t+1 (1-cycle grant latency).
- MEM_HANDSHAKE high at edge h → DONE/RDATA valid and MEM_ENABLE low after edge h. DONE lasts exactly one cycle.
- MEM_HANDSHAKE low at edge r (in RELEASE) → IDLE and GNT low after r. The next grant comes no earlier than r+1.
- Back-to-back, both requesting: grants alternate 0,1,0,1. Minimum 4 cycles per transaction (IDLE, WAIT, DONE edge, RELEASE) plus memory latency.
- Timeout fires on the edge where the counter equals TIMEOUT_CYCLES−1, i.e. TIMEOUT_CYCLES edges after WAIT entry.

## Test plan
- **Single request:** REQ=01, CTRL0=3'b000, ADDR0=0x10, memory answers 0xABCDEF123456 after 5 cycles → GNT=01 one cycle after REQ; MEM_ADDRESS=0x10; DONE=01 for one cycle; RDATA=0xABCDEF123456; TIMEOUT_ERR=0.
- **Simultaneous requests after reset:** REQ=11 held for 4 transactions → grant order 0,1,0,1; MEM_CTRL[0] follows CTRL0[0]/CTRL1[0] each time; exactly 4 DONE pulses.
- **Timeout:** TIMEOUT_CYCLES=8, MEM_HANDSHAKE tied 0 → DONE pulse 8 edges after WAIT entry; RDATA=0; TIMEOUT_ERR=1 and stays 1; MEM_ENABLE=0; state held in RELEASE only while handshake is high.
- **Stale handshake:** MEM_HANDSHAKE held high 3 cycles after completion while REQ=10 pending → GNT=10 only after handshake falls; exactly one DONE for the first transaction.
- **Input change during WAIT:** ADDR0 changed mid-transaction → MEM_ADDRESS unchanged until the next grant.
- **Reset mid-WAIT:** RESET pulsed during WAIT → next edge: MEM_ENABLE=0, GNT=0, no DONE, BUSY=0; the next REQ=11 grants requester 0.
